if_fetch_unit: RTL and testbench

//  Instruction-fetch stage; drives the IF/ID pipeline register. Owns the PC, issues

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_hold_buffer.sv | 32 +++
 rtl/if_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
// Optional feature macro used by the fetch unit: FETCH_ALIGN_CHECK_EN
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;  // text segment base
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  // ST_ERROR is only reachable when the alignment check is built in
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

  // Word-align an address by clearing the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// Capture register for the fetched word while the hazard unit stalls IF/ID.
// load wins over clear; an empty buffer reads back CLR_VAL.
module if_hold_buffer
  import mips_pkg::*;
#(
  parameter int            W       = 32,
  parameter logic [W-1:0]  CLR_VAL = NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld
);

  // Capture on load, return to empty on clear or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= CLR_VAL;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (clear) begin
      dout <= CLR_VAL;
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a ready-based imem, holds the
// fetched word across stalls, applies redirects and drives IF/ID valid/flush.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky
// misalign_o and park the unit in ST_ERROR until an aligned redirect or reset.
// Without it, redirect targets are silently word-aligned.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o,
  output logic        misalign_o
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_inc;
  logic [31:0]  pending_pc, pending_nxt;
  logic [31:0]  tgt;
  logic         tgt_bad;
  logic         req, valid, flush;
  logic [31:0]  instr;
  logic         hb_load, hb_clear, hb_vld;
  logic [31:0]  hb_data;

  assign pc_inc = pc + 32'd4;  // wraps modulo 2^32

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_nxt;
  assign tgt     = redirect_pc_i;
  assign tgt_bad = |redirect_pc_i[1:0];
`else
  assign tgt     = word_align(redirect_pc_i);
  assign tgt_bad = 1'b0;
`endif

  if_hold_buffer #(.W(32), .CLR_VAL(NOP_INSTR)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hb_load),
    .clear (hb_clear),
    .din   (imem_rdata_i),
    .dout  (hb_data),
    .vld   (hb_vld)
  );

  // Next-state, next-PC and IF/ID controls; redirect overrides everything else
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending_pc;
    req         = 1'b0;
    valid       = 1'b0;
    flush       = 1'b0;
    instr       = imem_rdata_i;
    hb_load     = 1'b0;
    hb_clear    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_nxt = misalign_q;
`endif

    case (state)
      ST_FETCH: begin
        req   = 1'b1;
        valid = imem_ready_i;
        if (imem_ready_i && !stall_i) begin
          pc_nxt = pc_inc;
        end else if (imem_ready_i && stall_i) begin
          hb_load   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        valid = hb_vld;
        instr = hb_data;
        if (!stall_i) begin
          pc_nxt    = pc_inc;
          hb_clear  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Old request still in flight: keep address, discard the returned word
        req = 1'b1;
        if (imem_ready_i) begin
          pc_nxt    = pending_pc;
          state_nxt = ST_FETCH;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_ERROR: ;
`endif
      default: state_nxt = ST_FETCH;
    endcase

    if (redirect_i) begin
      flush    = 1'b1;
      valid    = 1'b0;
      hb_load  = 1'b0;
      hb_clear = 1'b1;
      if (tgt_bad) begin
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_nxt = 1'b1;
        state_nxt    = ST_ERROR;
`endif
      end else begin
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_nxt = 1'b0;
`endif
        // An unfinished request must complete at its original address first
        if (req && !imem_ready_i) begin
          pending_nxt = tgt;
          state_nxt   = ST_DRAIN;
        end else begin
          pc_nxt    = tgt;
          state_nxt = ST_FETCH;
        end
      end
    end
  end

  // State, PC and redirect-pending registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      pending_pc <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_nxt;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared by reset or an aligned redirect
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_nxt;
  end
  assign misalign_o = misalign_q & ~reset;
`else
  assign misalign_o = 1'b0;
`endif

  // Reset cycle presents an idle interface regardless of stale state
  assign imem_req_o  = req & ~reset;
  assign imem_addr_o = pc;
  assign if_valid_o  = valid & ~reset;
  assign flush_o     = flush & ~reset;
  assign if_pc4_o    = pc_inc;
  assign if_instr_o  = if_valid_o ? instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit: inputs are driven after the falling
// edge, outputs compared shortly after, and state advances on the rising edge.
module tb_if_fetch_unit;

  localparam logic [31:0] B   = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall_i, redirect_i, imem_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, if_valid_o, flush_o, misalign_o;
  logic [31:0] imem_addr_o, if_pc4_o, if_instr_o;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc4_o      (if_pc4_o),
    .if_instr_o    (if_instr_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o)
  );

  typedef struct {
    logic        rst, stall, redir, rdy;
    logic [31:0] rpc, rdata;
    logic        req;   // addr compared only when a request is expected
    logic [31:0] addr;
    logic        vld;   // pc4 compared only when valid is expected
    logic [31:0] pc4, instr;
    logic        flush, mis;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic stall, logic redir, logic [31:0] rpc,
                              logic rdy, logic [31:0] rdata, logic req, logic [31:0] addr,
                              logic vld, logic [31:0] pc4, logic [31:0] instr,
                              logic flush, logic mis);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.rdy = rdy; v.rdata = rdata; v.req = req; v.addr = addr;
    v.vld = vld; v.pc4 = pc4; v.instr = instr; v.flush = flush; v.mis = mis;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic bad;
    @(negedge clk);
    reset = v.rst; stall_i = v.stall; redirect_i = v.redir; redirect_pc_i = v.rpc;
    imem_ready_i = v.rdy; imem_rdata_i = v.rdata;
    #1;
    bad = 1'b0;
    if (imem_req_o !== v.req)                bad = 1'b1;
    if (v.req && imem_addr_o !== v.addr)     bad = 1'b1;
    if (if_valid_o !== v.vld)                bad = 1'b1;
    if (v.vld && if_pc4_o !== v.pc4)         bad = 1'b1;
    if (if_instr_o !== v.instr)              bad = 1'b1;
    if (flush_o !== v.flush)                 bad = 1'b1;
    if (misalign_o !== v.mis)                bad = 1'b1;
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL %s: got req=%b addr=%h vld=%b pc4=%h instr=%h flush=%b mis=%b, want req=%b addr=%h vld=%b pc4=%h instr=%h flush=%b mis=%b",
               name, imem_req_o, imem_addr_o, if_valid_o, if_pc4_o, if_instr_o, flush_o, misalign_o,
               v.req, v.addr, v.vld, v.pc4, v.instr, v.flush, v.mis);
    end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ready_i = 1'b0; imem_rdata_i = '0;
    repeat (2) @(posedge clk);

    //            rst st rd rpc            rdy rdata           req addr           vld pc4            instr         fl mis
    tbl.push_back(mk(1, 0, 0, 0,           1, 32'hAAAA_0000, 0, 0,             0, 0,             NOP,          0, 0)); // reset state
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h1111_0000, 1, B,             1, B+4,           32'h1111_0000,0, 0)); // 0-wait stream
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h1111_0001, 1, B+4,           1, B+8,           32'h1111_0001,0, 0));
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h1111_0002, 1, B+8,           1, B+12,          32'h1111_0002,0, 0));
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h1111_0003, 1, B+12,          1, B+16,          32'h1111_0003,0, 0));
    tbl.push_back(mk(0, 1, 0, 0,           1, 32'h2222_0004, 1, B+16,          1, B+20,          32'h2222_0004,0, 0)); // stall capture
    tbl.push_back(mk(0, 1, 0, 0,           0, 32'hDEAD_BEEF, 0, 0,             1, B+20,          32'h2222_0004,0, 0)); // held, no req
    tbl.push_back(mk(0, 1, 0, 0,           0, 32'hDEAD_BEEF, 0, 0,             1, B+20,          32'h2222_0004,0, 0));
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'hDEAD_BEEF, 0, 0,             1, B+20,          32'h2222_0004,0, 0)); // release
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h3333_0005, 1, B+20,          1, B+24,          32'h3333_0005,0, 0)); // pc+4 after hold
    tbl.push_back(mk(0, 0, 1, B+32'h100,   0, 0,             1, B+24,          0, 0,             NOP,          1, 0)); // redirect mid-req
    tbl.push_back(mk(0, 0, 0, 0,           0, 0,             1, B+24,          0, 0,             NOP,          0, 0)); // drain, addr held
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'hBAD0_BAD0, 1, B+24,          0, 0,             NOP,          0, 0)); // word discarded
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h4444_0006, 1, B+32'h100,     1, B+32'h104,     32'h4444_0006,0, 0)); // at target
    tbl.push_back(mk(0, 1, 1, B+32'h200,   1, 32'h5555_0007, 1, B+32'h104,     0, 0,             NOP,          1, 0)); // redirect beats stall
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h5555_0008, 1, B+32'h200,     1, B+32'h204,     32'h5555_0008,0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,1, 0,            1, B+32'h204,     0, 0,             NOP,          1, 0)); // go to top of memory
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h6666_0009, 1, 32'hFFFF_FFFC, 1, 32'h0,         32'h6666_0009,0, 0)); // pc4 wraps
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h6666_000A, 1, 32'h0,         1, 32'h4,         32'h6666_000A,0, 0));
    tbl.push_back(mk(0, 1, 0, 0,           1, 32'h7777_000B, 1, 32'h4,         1, 32'h8,         32'h7777_000B,0, 0)); // into HOLD
    tbl.push_back(mk(0, 1, 1, B+32'h300,   0, 0,             0, 0,             0, 0,             NOP,          1, 0)); // redirect from HOLD
    tbl.push_back(mk(0, 0, 0, 0,           1, 32'h7777_000C, 1, B+32'h300,     1, B+32'h304,     32'h7777_000C,0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Drain: second redirect replaces the pending target
    apply(mk(0,0,1,B+32'h400,0,0,            1,B+32'h304,0,0,NOP,1,0), "drain_redir1");
    apply(mk(0,0,1,B+32'h500,0,0,            1,B+32'h304,0,0,NOP,1,0), "drain_redir2");
    apply(mk(0,0,0,0,        1,32'hBAD1,     1,B+32'h304,0,0,NOP,0,0), "drain_done");
    apply(mk(0,0,0,0,        1,32'h8888_000D,1,B+32'h500,1,B+32'h504,32'h8888_000D,0,0), "last_wins");
    // Drain: redirect arriving with ready jumps straight to the new target
    apply(mk(0,0,1,B+32'h600,0,0,            1,B+32'h504,0,0,NOP,1,0), "drain2_enter");
    apply(mk(0,0,1,B+32'h700,1,32'hBAD2,     1,B+32'h504,0,0,NOP,1,0), "drain2_redir_rdy");
    apply(mk(0,0,0,0,        1,32'h9999_000E,1,B+32'h700,1,B+32'h704,32'h9999_000E,0,0), "drain2_target");
    // Wait state in FETCH presents a bubble
    apply(mk(0,0,0,0,        0,32'hBAD3,     1,B+32'h704,0,0,NOP,0,0), "fetch_wait");

`ifdef FETCH_ALIGN_CHECK_EN
    apply(mk(0,0,1,B+32'h802,1,0,            1,B+32'h704,0,0,NOP,1,0), "misalign_redir");
    apply(mk(0,0,0,0,        1,32'hBAD4,     0,0,        0,0,NOP,0,1), "error_idle1");
    apply(mk(0,1,0,0,        1,32'hBAD4,     0,0,        0,0,NOP,0,1), "error_idle2");
    apply(mk(0,0,1,B+32'h800,0,0,            0,0,        0,0,NOP,1,1), "error_recover");
    apply(mk(0,0,0,0,        1,32'hAAAA_000F,1,B+32'h800,1,B+32'h804,32'hAAAA_000F,0,0), "recovered");
`else
    apply(mk(0,0,1,B+32'h802,1,0,            1,B+32'h704,0,0,NOP,1,0), "unaligned_redir");
    apply(mk(0,0,0,0,        1,32'hAAAA_000F,1,B+32'h800,1,B+32'h804,32'hAAAA_000F,0,0), "forced_align");
`endif

    // Reset in the middle of an outstanding request abandons it
    apply(mk(0,0,0,0,        0,0,            1,B+32'h804,0,0,NOP,0,0), "pre_reset_wait");
    apply(mk(1,0,0,0,        0,0,            0,0,        0,0,NOP,0,0), "mid_reset");
    apply(mk(0,0,0,0,        1,32'hBBBB_0010,1,B,        1,B+4,32'hBBBB_0010,0,0), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Guard against a hung simulation
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got %0d vectors, want completion", nvec);
    $fatal(1);
  end

endmodule
